serial_bus_arbiter: RTL and testbench

- Central arbiter for the shared serial bus. Grants one initiator port at a time using round-robin priority.
- Inserts a one-cycle turnaround between owners so tristate drivers on bus_data hand over cleanly.
- Tracks one outstanding split transaction: the split initiator is parked, and when the target signals resume it is re-granted ahead of all other requesters.

---
 rtl/serial_bus_arbiter.sv | 168 ++++++++++++++++
 tb/tb_serial_bus_arbiter.sv | 166 ++++++++++++++++
 2 files changed

// File: rtl/serial_bus_arbiter.sv
// Round-robin arbiter for the shared serial bus with turnaround cycle and one parked split.
// Optional grant-hold timeout is compiled in with `define ARB_TIMEOUT_EN.
module serial_bus_arbiter #(
  parameter int NUM_INIT = 2,
  parameter int IDX_W    = (NUM_INIT > 2) ? $clog2(NUM_INIT) : 1,
  parameter int TIMEOUT  = 255
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [NUM_INIT-1:0] arb_req,
  input  logic                target_split,
  input  logic                split_resume,
  output logic [NUM_INIT-1:0] arb_grant,
  output logic [IDX_W-1:0]    grant_idx,
  output logic                bus_busy,
  output logic                split_pending,
  output logic                split_err,
  output logic                timeout
);

  typedef enum logic [1:0] {IDLE, GRANT, TURN} state_t;

  state_t              state_q, state_n;
  logic [NUM_INIT-1:0] grant_q, grant_n;
  logic [IDX_W-1:0]    idx_q, idx_n;
  logic                busy_q;
  logic                sp_q, sp_n;
  logic [IDX_W-1:0]    sid_q, sid_n;
  logic [IDX_W-1:0]    rr_q, rr_n;
  logic                rf_q, rf_n;
  logic                serr_q, serr_n;
  logic [NUM_INIT-1:0] req_m;
  logic [IDX_W:0]      cand;
  logic [IDX_W-1:0]    win;
  logic                win_vld;
`ifdef ARB_TIMEOUT_EN
  logic [7:0]          cnt_q, cnt_n;
  logic                tout_q, tout_n;
`endif

  function automatic logic [NUM_INIT-1:0] onehot(input logic [IDX_W-1:0] i);
    onehot    = '0;
    onehot[i] = 1'b1;
  endfunction

  // The parked split initiator is invisible to round-robin until resumed.
  assign req_m = arb_req & ~(sp_q ? onehot(sid_q) : '0);

  // Scan from rr_ptr+1 upward; iterating backwards lets the nearest hit win.
  always_comb begin
    win_vld = 1'b0;
    win     = '0;
    cand    = '0;
    for (int i = NUM_INIT; i >= 1; i--) begin
      cand = {1'b0, rr_q} + (IDX_W+1)'(i);
      if (cand >= (IDX_W+1)'(NUM_INIT)) cand = cand - (IDX_W+1)'(NUM_INIT);
      if (req_m[cand[IDX_W-1:0]]) begin
        win_vld = 1'b1;
        win     = cand[IDX_W-1:0];
      end
    end
  end

  always_comb begin
    state_n = state_q;
    grant_n = grant_q;
    idx_n   = idx_q;
    sp_n    = sp_q;
    sid_n   = sid_q;
    rr_n    = rr_q;
    rf_n    = rf_q | (sp_q & split_resume);
    serr_n  = 1'b0;
`ifdef ARB_TIMEOUT_EN
    cnt_n   = cnt_q;
    tout_n  = 1'b0;
`endif
    case (state_q)
      IDLE: begin
        if (sp_q && rf_q) begin
          grant_n = onehot(sid_q);
          idx_n   = sid_q;
          sp_n    = 1'b0;
          rf_n    = 1'b0;
          state_n = GRANT;
`ifdef ARB_TIMEOUT_EN
          cnt_n   = '0;
`endif
        end else if (win_vld) begin
          grant_n = onehot(win);
          idx_n   = win;
          rr_n    = win;
          state_n = GRANT;
`ifdef ARB_TIMEOUT_EN
          cnt_n   = '0;
`endif
        end
      end
      GRANT: begin
        if (target_split) begin
          if (sp_q) serr_n = 1'b1;
          else begin
            sp_n  = 1'b1;
            sid_n = idx_q;
          end
          grant_n = '0;
          state_n = TURN;
        end else if (!arb_req[idx_q]) begin
          grant_n = '0;
          state_n = TURN;
        end else begin
`ifdef ARB_TIMEOUT_EN
          cnt_n = cnt_q + 8'd1;
          if (cnt_n == 8'(TIMEOUT)) begin
            tout_n  = 1'b1;
            grant_n = '0;
            state_n = TURN;
          end
`endif
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      grant_q <= '0;
      idx_q   <= '0;
      busy_q  <= 1'b0;
      sp_q    <= 1'b0;
      sid_q   <= '0;
      rr_q    <= IDX_W'(NUM_INIT - 1);
      rf_q    <= 1'b0;
      serr_q  <= 1'b0;
`ifdef ARB_TIMEOUT_EN
      cnt_q   <= '0;
      tout_q  <= 1'b0;
`endif
    end else begin
      state_q <= state_n;
      grant_q <= grant_n;
      idx_q   <= idx_n;
      busy_q  <= |grant_n;
      sp_q    <= sp_n;
      sid_q   <= sid_n;
      rr_q    <= rr_n;
      rf_q    <= rf_n;
      serr_q  <= serr_n;
`ifdef ARB_TIMEOUT_EN
      cnt_q   <= cnt_n;
      tout_q  <= tout_n;
`endif
    end
  end

  assign arb_grant     = grant_q;
  assign grant_idx     = idx_q;
  assign bus_busy      = busy_q;
  assign split_pending = sp_q;
  assign split_err     = serr_q;
`ifdef ARB_TIMEOUT_EN
  assign timeout       = tout_q;
`else
  assign timeout       = 1'b0;
`endif

endmodule

// File: tb/tb_serial_bus_arbiter.sv
// Directed bench for serial_bus_arbiter (NUM_INIT=2), hand-computed expectations.
module tb_serial_bus_arbiter;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [1:0] arb_req;
  logic       target_split;
  logic       split_resume;
  logic [1:0] arb_grant;
  logic [0:0] grant_idx;
  logic       bus_busy;
  logic       split_pending;
  logic       split_err;
  logic       timeout;

  int n_chk  = 0;
  int n_fail = 0;

  serial_bus_arbiter #(.NUM_INIT(2), .TIMEOUT(8)) dut (
    .clk(clk), .rst_n(rst_n), .arb_req(arb_req), .target_split(target_split),
    .split_resume(split_resume), .arb_grant(arb_grant), .grant_idx(grant_idx),
    .bus_busy(bus_busy), .split_pending(split_pending), .split_err(split_err),
    .timeout(timeout)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_grant(input string tag, input logic [1:0] g);
    chk(tag, 32'(arb_grant), 32'(g));
    chk({tag, "_busy"}, 32'(bus_busy), 32'(|g));
  endtask

  initial begin
    logic [1:0] own;
    rst_n = 1'b0; arb_req = 2'b00; target_split = 1'b0; split_resume = 1'b0;
    step(); step();
    chk_grant("rst_grant", 2'b00);
    chk("rst_idx", 32'(grant_idx), 32'd0);
    chk("rst_sp", 32'(split_pending), 32'd0);
    chk("rst_serr", 32'(split_err), 32'd0);
    chk("rst_tout", 32'(timeout), 32'd0);

    // single request, 1-cycle latency, release -> TURN -> IDLE
    rst_n = 1'b1; arb_req = 2'b01;
    step();
    chk_grant("g0", 2'b01);
    chk("g0_idx", 32'(grant_idx), 32'd0);
    arb_req = 2'b00;
    step(); chk_grant("g0_turn", 2'b00);
    chk("g0_idx_hold", 32'(grant_idx), 32'd0);
    step(); chk_grant("g0_idle", 2'b00);

    // round robin alternation with 2 empty cycles between owners
    arb_req = 2'b11;
    for (int k = 0; k < 4; k++) begin
      own = (k % 2 == 0) ? 2'b10 : 2'b01;
      step(); chk_grant("rr_grant", own);
      chk("rr_idx", 32'(grant_idx), (k % 2 == 0) ? 32'd1 : 32'd0);
      for (int h = 0; h < 3; h++) begin
        step(); chk_grant("rr_hold", own);
      end
      arb_req = 2'b11 & ~own;
      step(); chk_grant("rr_gap1", 2'b00);
      arb_req = 2'b11;
      step(); chk_grant("rr_gap2", 2'b00);
    end
    arb_req = 2'b00;
    step();

    // split by owner 0, masked, resumed ahead of others without its req
    arb_req = 2'b01;
    step(); chk_grant("sp_g0", 2'b01);
    target_split = 1'b1;
    step(); chk_grant("sp_drop", 2'b00);
    chk("sp_pend", 32'(split_pending), 32'd1);
    target_split = 1'b0; arb_req = 2'b11;
    step(); chk_grant("sp_idle", 2'b00);
    step(); chk_grant("sp_mask", 2'b10);
    split_resume = 1'b1;
    step(); split_resume = 1'b0;
    chk_grant("sp_keep", 2'b10);
    arb_req = 2'b00;
    step(); chk_grant("sp_turn", 2'b00);
    step(); chk_grant("sp_idle2", 2'b00);
    step(); chk_grant("sp_resume", 2'b01);
    chk("sp_res_idx", 32'(grant_idx), 32'd0);
    chk("sp_res_clr", 32'(split_pending), 32'd0);
    step(); chk_grant("sp_rel", 2'b00);
    step();

    // second split refused while one is parked
    arb_req = 2'b01;
    step(); chk_grant("se_g0", 2'b01);
    target_split = 1'b1;
    step(); target_split = 1'b0;
    chk("se_sp", 32'(split_pending), 32'd1);
    arb_req = 2'b10;
    step(); step(); chk_grant("se_g1", 2'b10);
    target_split = 1'b1;
    step(); target_split = 1'b0;
    chk("se_err", 32'(split_err), 32'd1);
    chk_grant("se_drop", 2'b00);
    chk("se_sp_keep", 32'(split_pending), 32'd1);
    arb_req = 2'b00;
    step(); chk("se_err_pulse", 32'(split_err), 32'd0);
    split_resume = 1'b1;
    step(); split_resume = 1'b0;
    chk_grant("se_noyet", 2'b00);
    step(); chk_grant("se_sid0", 2'b01);
    step(); step();

    // reset mid-grant clears split and rr_ptr
    arb_req = 2'b01;
    step(); chk_grant("rm_g0", 2'b01);
    target_split = 1'b1;
    step(); target_split = 1'b0; arb_req = 2'b11;
    step(); step(); chk_grant("rm_g1", 2'b10);
    rst_n = 1'b0;
    step(); chk_grant("rm_rst", 2'b00);
    chk("rm_sp", 32'(split_pending), 32'd0);
    rst_n = 1'b1;
    step(); chk_grant("rm_first", 2'b01);
    rst_n = 1'b0;
    step(); chk_grant("rm_rst2", 2'b00);
    rst_n = 1'b1;
    step(); chk_grant("rm_rr", 2'b01);
    rst_n = 1'b0;
    step(); rst_n = 1'b1;

`ifdef ARB_TIMEOUT_EN
    arb_req = 2'b11;
    step(); chk_grant("to_g0", 2'b01);
    for (int k = 1; k < 8; k++) begin
      step(); chk_grant("to_hold", 2'b01);
      chk("to_quiet", 32'(timeout), 32'd0);
    end
    step(); chk_grant("to_drop", 2'b00);
    chk("to_pulse", 32'(timeout), 32'd1);
    step(); chk("to_pulse_end", 32'(timeout), 32'd0);
    step(); chk_grant("to_next", 2'b10);
`else
    arb_req = 2'b01;
    step(); chk_grant("nt_g0", 2'b01);
    for (int k = 0; k < 20; k++) step();
    chk_grant("nt_hold", 2'b01);
    chk("nt_tout", 32'(timeout), 32'd0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
